overdrive_clamp: RTL and testbench
==================================

OVERDRIVE_CLAMP -- requirements
Module: overdrive_clamp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: sample width, two's-complement signed.
REQ-002 SHALL have parameter FRAC_W, default 12: fractional bits; ONE = 2**FRAC_W = 4096 represents 1.0.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port i_valid, input, 1: i_sample is valid this cycle.
REQ-006 SHALL have port i_sample, input, DATA_W, signed: input sample in Q(DATA_W-FRAC_W).FRAC_W format.
REQ-007 SHALL have port o_valid, output, 1: o_sample is valid this cycle.
REQ-008 SHALL have port o_sample, output, DATA_W, signed: clamped/shaped output sample in the same Q format.

Function
REQ-009 SHALL define mul(a,b) = (a*b) / ONE, using a full-precision signed product and division truncating toward zero, not floor.
REQ-010 SHALL output -ONE/2 (-2048) when x <= -ONE.
REQ-011 SHALL output +ONE/2 (+2048) when x >= +ONE.
REQ-012 SHALL otherwise output (mul(mul(x,x),x) + 3*x) / 4, with the /4 truncating toward zero.
REQ-013 SHALL size intermediates so no overflow occurs for |x| < ONE: product >= 2*FRAC_W+2 bits and sum >= FRAC_W+4 bits signed; the result is sign-extended to DATA_W.
REQ-014 SHALL evaluate the range comparisons of REQ-010/011 on the full DATA_W input; the discontinuity at |x| = ONE (4095 -> 4094, 4096 -> 2048) is intended behaviour.
REQ-015 SHALL be fully pipelined with 3 cycles of latency: stage 1 registers x, x*x and the range flags; stage 2 registers the cube; stage 3 registers the sum, scale and clamp select.
REQ-016 SHALL accept one sample per cycle; there is no backpressure.
REQ-017 SHALL make o_valid equal i_valid delayed by exactly 3 cycles.
REQ-018 SHALL advance data registers regardless of i_valid; o_sample is don't-care when o_valid = 0.
REQ-019 SHALL be bit-exact to REQ-009..REQ-012 for every input in [-2**16, 2**16).

Reset
REQ-020 SHALL, when i_rst_n = 0 at a rising edge, clear all pipeline valid bits and data registers to 0, so o_valid = 0 and o_sample = 0.
REQ-021 SHALL discard samples in flight at reset; the first valid output appears 3 cycles after the first i_valid sampled with i_rst_n = 1.
REQ-022 SHALL have no asynchronous reset path.

Structure
REQ-023 SHALL place DATA_W, FRAC_W, ONE and typedef sample_t (signed DATA_W logic) in package overdrive_pkg.
REQ-024 SHALL implement mul in one sub-module, fx_mul: a signed Q multiply with truncate-toward-zero rescale (negative product: add ONE-1 before the arithmetic shift), instantiated twice.
REQ-025 SHALL implement the /4 as a toward-zero divide (negative value: add 3 before the arithmetic shift by 2).

Verification
REQ-026 SHALL check these single samples, each valid, expecting the output 3 cycles later: 0 -> 0; 2048 -> 1664; -2048 -> -1664; 100 -> 75; -100 -> -75; -3 -> -2; -1 -> 0.
REQ-027 SHALL check the boundaries: 4095 -> 4094; -4095 -> -4094; 4096 -> 2048; -4096 -> -2048; 65535 -> 2048; -65536 -> -2048.
REQ-028 SHALL sweep back-to-back inputs from -65536 to 65534 in steps of 2 against a reference model, requiring a match every cycle with o_valid continuously high.
REQ-029 SHALL check valid gaps: an i_valid pattern of 1,0,1,1 must produce the same o_valid pattern delayed by 3 cycles.
REQ-030 SHALL check reset mid-stream: assert i_rst_n = 0 for one cycle while 3 samples are in flight; o_valid must be 0 and o_sample 0 on the following cycle, and no stale outputs may appear.

Source files
------------

// File: rtl/overdrive_pkg.sv
// Shared types and constants for the overdrive clamp datapath.
package overdrive_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 12;
  localparam int ONE    = 1 << FRAC_W;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Which output the final stage selects: the shaped polynomial or a rail.
  typedef enum logic [1:0] {
    SEL_MID = 2'd0,
    SEL_LO  = 2'd1,
    SEL_HI  = 2'd2
  } clamp_sel_t;

endpackage

// File: rtl/overdrive_clamp_fx_mul.sv
// Signed Q-format multiply, rescaled by 2**FRAC_W with truncation toward zero.
module fx_mul #(
  parameter int IN_W   = 14,
  parameter int FRAC_W = 12
) (
  input  logic signed [IN_W-1:0] a,
  input  logic signed [IN_W-1:0] b,
  output logic signed [IN_W-1:0] p
);

  localparam int PW = 2 * IN_W;
  localparam logic signed [PW-1:0] BIAS = PW'((1 << FRAC_W) - 1);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] adj;

  // Full-precision product; negative products are biased so the arithmetic
  // shift rounds toward zero instead of toward minus infinity.
  always_comb begin
    prod = PW'(a) * PW'(b);
    adj  = prod[PW-1] ? prod + BIAS : prod;
    p    = IN_W'(adj >>> FRAC_W);
  end

endmodule

// File: rtl/overdrive_clamp.sv
// Soft-clip overdrive: (x^3 + 3x)/4 inside (-1, 1), hard rails at +/-0.5
// outside. Three pipeline stages, one sample per cycle, no backpressure.
module overdrive_clamp
  import overdrive_pkg::*;
#(
  parameter int DATA_W = overdrive_pkg::DATA_W,
  parameter int FRAC_W = overdrive_pkg::FRAC_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_sample
);

  // Narrow datapath: only |x| < ONE reaches the polynomial, so FRAC_W+2 bits
  // cover x, x*x and the cube; the sum of cube and 3x needs FRAC_W+4 bits.
  localparam int NW = FRAC_W + 2;
  localparam int SW = FRAC_W + 4;

  localparam int ONE_I = 1 << FRAC_W;
  localparam logic signed [DATA_W-1:0] POS_ONE  = DATA_W'(ONE_I);
  localparam logic signed [DATA_W-1:0] NEG_ONE  = -POS_ONE;
  localparam logic signed [DATA_W-1:0] POS_HALF = DATA_W'(ONE_I / 2);
  localparam logic signed [DATA_W-1:0] NEG_HALF = -POS_HALF;

  logic signed [NW-1:0] x_n;
  logic signed [NW-1:0] sq_n;
  logic signed [NW-1:0] cube_n;
  clamp_sel_t           sel_n;

  logic                 v1, v2;
  logic signed [NW-1:0] x1, xx1, x2, cube2;
  clamp_sel_t           sel1, sel2;

  logic signed [SW-1:0]     sum3;
  logic signed [SW-1:0]     sum_adj;
  logic signed [SW-1:0]     quot;
  logic signed [DATA_W-1:0] res;

  assign x_n = i_sample[NW-1:0];

  fx_mul #(.IN_W(NW), .FRAC_W(FRAC_W)) u_sq (
    .a (x_n),
    .b (x_n),
    .p (sq_n)
  );

  fx_mul #(.IN_W(NW), .FRAC_W(FRAC_W)) u_cube (
    .a (xx1),
    .b (x1),
    .p (cube_n)
  );

  // Range decision taken on the full-width input, before narrowing.
  always_comb begin
    sel_n = SEL_MID;
    if (i_sample <= NEG_ONE)
      sel_n = SEL_LO;
    else if (i_sample >= POS_ONE)
      sel_n = SEL_HI;
  end

  // Final-stage arithmetic: cube + 3x, divided by 4 toward zero, then rail select.
  always_comb begin
    sum3    = SW'(cube2) + SW'(x2) + SW'(x2) + SW'(x2);
    sum_adj = sum3[SW-1] ? sum3 + SW'(3) : sum3;
    quot    = sum_adj >>> 2;
    unique case (sel2)
      SEL_LO:  res = NEG_HALF;
      SEL_HI:  res = POS_HALF;
      default: res = DATA_W'(quot);
    endcase
  end

  // Pipeline registers; data advances every cycle, valid travels alongside.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1       <= 1'b0;
      x1       <= '0;
      xx1      <= '0;
      sel1     <= SEL_MID;
      v2       <= 1'b0;
      x2       <= '0;
      cube2    <= '0;
      sel2     <= SEL_MID;
      o_valid  <= 1'b0;
      o_sample <= '0;
    end else begin
      v1       <= i_valid;
      x1       <= x_n;
      xx1      <= sq_n;
      sel1     <= sel_n;
      v2       <= v1;
      x2       <= x1;
      cube2    <= cube_n;
      sel2     <= sel1;
      o_valid  <= v2;
      o_sample <= res;
    end
  end

endmodule

// File: tb/tb_overdrive_clamp.sv
// Self-checking bench for overdrive_clamp against an arithmetic reference.
module tb_overdrive_clamp;
  import overdrive_pkg::*;

  logic    i_clk = 1'b0;
  logic    i_rst_n;
  logic    i_valid;
  sample_t i_sample;
  logic    o_valid;
  sample_t o_sample;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit     v;
    bit     chk;
    longint val;
    string  tag;
  } exp_t;

  exp_t q[$];

  overdrive_clamp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_sample (i_sample),
    .o_valid  (o_valid),
    .o_sample (o_sample)
  );

  always #5 i_clk = ~i_clk;

  // Reference: SV integer division truncates toward zero, matching the rules.
  function automatic longint ref_out(input longint x);
    longint m1, m2;
    if (x <= -ONE) return -(ONE / 2);
    if (x >= ONE) return ONE / 2;
    m1 = (x * x) / ONE;
    m2 = (m1 * x) / ONE;
    return (m2 + 3 * x) / 4;
  endfunction

  task automatic step(input bit v, input longint x, input bit rstn, input string tag);
    exp_t e;
    i_valid  = v;
    i_sample = 32'(x);
    i_rst_n  = rstn;
    @(posedge i_clk);
    #1;
    if (!rstn) begin
      q.delete();
      checks++;
      assert (o_valid === 1'b0) else begin
        errors++;
        $error("FAIL %s_valid: got %0b want 0", tag, o_valid);
      end
      checks++;
      assert (o_sample === 32'sd0) else begin
        errors++;
        $error("FAIL %s_sample: got %0d want 0", tag, o_sample);
      end
      e = '{v: 1'b0, chk: 1'b1, val: 0, tag: "flush"};
      q.push_back(e);
      q.push_back(e);
    end else begin
      e = '{v: v, chk: v, val: ref_out(x), tag: tag};
      q.push_back(e);
      if (q.size() >= 3) begin
        e = q.pop_front();
        checks++;
        assert (o_valid === e.v) else begin
          errors++;
          $error("FAIL %s_valid: got %0b want %0b", e.tag, o_valid, e.v);
        end
        if (e.chk) begin
          checks++;
          assert (o_sample === 32'(e.val)) else begin
            errors++;
            $error("FAIL %s_sample: got %0d want %0d", e.tag, o_sample, e.val);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, "idle");
  endtask

  longint directed [13] = '{0, 2048, -2048, 100, -100, -3, -1,
                            4095, -4095, 4096, -4096, 65535, -65536};

  initial begin
    int     sel;
    int     xi;
    longint expect_tbl [13] = '{0, 1664, -1664, 75, -75, -2, 0,
                                4094, -4094, 2048, -2048, 2048, -2048};

    // Reset state, two cycles.
    step(1'b0, 0, 1'b0, "reset");
    step(1'b0, 0, 1'b0, "reset");
    idle(3);

    // Hand-derived expectations cross-check the reference model itself.
    for (int i = 0; i < 13; i++) begin
      checks++;
      assert (ref_out(directed[i]) === expect_tbl[i]) else begin
        errors++;
        $error("FAIL model_%0d: got %0d want %0d", directed[i], ref_out(directed[i]), expect_tbl[i]);
      end
    end

    // Single isolated samples, including the +/-ONE boundaries.
    for (int i = 0; i < 13; i++) begin
      step(1'b1, directed[i], 1'b1, $sformatf("single_%0d", directed[i]));
      idle(3);
    end

    // Back-to-back sweep across the full exact range.
    for (longint x = -65536; x <= 65534; x += 2) step(1'b1, x, 1'b1, "sweep");
    idle(3);

    // Valid gaps 1,0,1,1.
    step(1'b1, 1234, 1'b1, "gap");
    step(1'b0, 777, 1'b1, "gap");
    step(1'b1, -3000, 1'b1, "gap");
    step(1'b1, 5000, 1'b1, "gap");
    idle(4);

    // Reset with three samples in flight; none may emerge afterwards.
    step(1'b1, 1000, 1'b1, "inflight");
    step(1'b1, -1000, 1'b1, "inflight");
    step(1'b1, 3000, 1'b1, "inflight");
    step(1'b0, 0, 1'b0, "midreset");
    step(1'b1, 2048, 1'b1, "post_reset");
    idle(4);

    // Randomized traffic with random valid gaps across several magnitudes.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0:       xi = $urandom_range(0, 9000) - 4500;
        1:       xi = $urandom_range(0, 140000) - 70000;
        default: xi = $urandom;
      endcase
      step(1'($urandom_range(0, 1)), xi, 1'b1, "rand");
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
